uart_boot_loader: RTL and testbench

- Sits between the UART receive path and the 4096x16 program RAM. Holds the CPU in reset and loads a program image from the serial link.
- Parses a framed byte stream: sync, word count, big-endian 16-bit words, XOR checksum.
- Writes each word to RAM sequentially from address 0, then releases the CPU.
- Reports completion or a sticky error code.

---
 rtl/uart_boot_loader_pkg.sv | 22 ++
 rtl/uart_boot_loader_boot_timeout.sv | 30 +++
 rtl/uart_boot_loader.sv | 125 ++++++++++++
 tb/tb_uart_boot_loader.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_boot_loader_pkg.sv
// Shared types and constants for the UART boot loader.
package uart_boot_loader_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LEN_HI,
    ST_LEN_LO,
    ST_DATA_HI,
    ST_DATA_LO,
    ST_CSUM,
    ST_DONE,
    ST_ERROR
  } state_t;

  localparam logic [7:0] SYNC_BYTE = 8'hA5;

  localparam logic [1:0] ERR_NONE    = 2'd0;
  localparam logic [1:0] ERR_CSUM    = 2'd1;
  localparam logic [1:0] ERR_LEN     = 2'd2;
  localparam logic [1:0] ERR_TIMEOUT = 2'd3;

endpackage

// File: rtl/uart_boot_loader_boot_timeout.sv
// Inter-byte idle counter; expired flags the cycle the idle limit is hit without a byte.
module boot_timeout #(
  parameter int unsigned TIMEOUT_CYCLES = 1_000_000
) (
  input  logic clk,
  input  logic reset,
  input  logic enable,
  input  logic clear,
  output logic expired
);

  localparam int unsigned     CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cnt <= '0;
    end else if (!enable || clear) begin
      r_cnt <= '0;
    end else if (r_cnt != LIMIT) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  // A byte on the limit edge wins, so clear masks expiry.
  assign expired = enable && !clear && (r_cnt == LIMIT);

endmodule

// File: rtl/uart_boot_loader.sv
// Parses a framed serial image (sync, length, big-endian words, XOR checksum) into program RAM.
module uart_boot_loader #(
  parameter int unsigned ADDR_W         = 12,
  parameter int unsigned DATA_W         = 16,
  parameter logic [7:0]  SYNC_BYTE      = uart_boot_loader_pkg::SYNC_BYTE,
  parameter int unsigned TIMEOUT_CYCLES = 1_000_000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [7:0]        rx_byte,
  input  logic              rx_valid,
  output logic              ram_w_en,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_w_data,
  output logic              cpu_hold,
  output logic              load_done,
  output logic [1:0]        load_err
);

  import uart_boot_loader_pkg::*;

  state_t              r_state;
  logic [15:0]         r_len;
  logic [7:0]          r_hi;
  logic [7:0]          r_csum;
  logic [ADDR_W:0]     r_word_idx;
  logic                r_ram_w_en;
  logic [ADDR_W-1:0]   r_ram_addr;
  logic [DATA_W-1:0]   r_ram_w_data;
  logic                r_cpu_hold;
  logic                r_load_done;
  logic [1:0]          r_load_err;

  logic [15:0]         w_len;
  logic                w_in_frame;
  logic                w_expired;
  logic                w_last_word;

  assign w_len       = {r_len[15:8], rx_byte};
  assign w_in_frame  = r_state inside {ST_LEN_HI, ST_LEN_LO, ST_DATA_HI, ST_DATA_LO, ST_CSUM};
  assign w_last_word = (32'(r_word_idx) + 32'd1) == 32'(r_len);

  boot_timeout #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .clk    (clk),
    .reset  (reset),
    .enable (w_in_frame),
    .clear  (rx_valid),
    .expired(w_expired)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state      <= ST_IDLE;
      r_len        <= '0;
      r_hi         <= '0;
      r_csum       <= '0;
      r_word_idx   <= '0;
      r_ram_w_en   <= 1'b0;
      r_ram_addr   <= '0;
      r_ram_w_data <= '0;
      r_cpu_hold   <= 1'b1;
      r_load_done  <= 1'b0;
      r_load_err   <= ERR_NONE;
    end else begin
      r_ram_w_en <= 1'b0;
      if (rx_valid) begin
        case (r_state)
          ST_IDLE:    if (rx_byte == SYNC_BYTE) r_state <= ST_LEN_HI;
          ST_LEN_HI: begin
            r_len[15:8] <= rx_byte;
            r_state     <= ST_LEN_LO;
          end
          ST_LEN_LO: begin
            r_len <= w_len;
            if (32'(w_len) > (32'd1 << ADDR_W)) begin
              r_state    <= ST_ERROR;
              r_load_err <= ERR_LEN;
            end else if (w_len == 16'd0) begin
              r_state <= ST_CSUM;
            end else begin
              r_state <= ST_DATA_HI;
            end
          end
          ST_DATA_HI: begin
            r_hi    <= rx_byte;
            r_csum  <= r_csum ^ rx_byte;
            r_state <= ST_DATA_LO;
          end
          ST_DATA_LO: begin
            r_csum       <= r_csum ^ rx_byte;
            r_ram_w_en   <= 1'b1;
            r_ram_addr   <= r_word_idx[ADDR_W-1:0];
            r_ram_w_data <= DATA_W'({r_hi, rx_byte});
            r_word_idx   <= r_word_idx + 1'b1;
            r_state      <= w_last_word ? ST_CSUM : ST_DATA_HI;
          end
          ST_CSUM: begin
            if (rx_byte == r_csum) begin
              r_state     <= ST_DONE;
              r_load_done <= 1'b1;
              r_cpu_hold  <= 1'b0;
            end else begin
              r_state    <= ST_ERROR;
              r_load_err <= ERR_CSUM;
            end
          end
          default: ;
        endcase
      end else if (w_in_frame && w_expired) begin
        r_state    <= ST_ERROR;
        r_load_err <= ERR_TIMEOUT;
      end
    end
  end

  assign ram_w_en   = r_ram_w_en;
  assign ram_addr   = r_ram_addr;
  assign ram_w_data = r_ram_w_data;
  assign cpu_hold   = r_cpu_hold;
  assign load_done  = r_load_done;
  assign load_err   = r_load_err;

endmodule

// File: tb/tb_uart_boot_loader.sv
// Directed bench for uart_boot_loader: framing, checksum, length, timeout and mid-load reset.
`timescale 1ns/1ps
module tb_uart_boot_loader;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [7:0]  rx_byte = '0;
  logic        rx_valid = 1'b0;
  logic        ram_w_en;
  logic [11:0] ram_addr;
  logic [15:0] ram_w_data;
  logic        cpu_hold;
  logic        load_done;
  logic [1:0]  load_err;

  int checks = 0;
  int errors = 0;
  logic [27:0] wlog[$];

  uart_boot_loader #(
    .ADDR_W(12),
    .DATA_W(16),
    .SYNC_BYTE(8'hA5),
    .TIMEOUT_CYCLES(50)
  ) dut (
    .clk(clk), .reset(reset), .rx_byte(rx_byte), .rx_valid(rx_valid),
    .ram_w_en(ram_w_en), .ram_addr(ram_addr), .ram_w_data(ram_w_data),
    .cpu_hold(cpu_hold), .load_done(load_done), .load_err(load_err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (reset && ram_w_en === 1'b1) wlog.push_back({ram_addr, ram_w_data});
  end

  // Called at posedge+1; the byte is consumed on the next posedge.
  task automatic drive(input logic [7:0] b);
    rx_byte  = b;
    rx_valid = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n);
    rx_valid = 1'b0;
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic apply_reset();
    rx_valid = 1'b0;
    reset    = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    wlog.delete();
  endtask

  task automatic check_status(input string name, input logic exp_done,
                              input logic exp_hold, input logic [1:0] exp_err);
    checks++;
    if ({load_done, cpu_hold, load_err} !== {exp_done, exp_hold, exp_err}) begin
      errors++;
      $display("FAIL %s: done/hold/err got %b/%b/%0d expected %b/%b/%0d",
               name, load_done, cpu_hold, load_err, exp_done, exp_hold, exp_err);
    end
  endtask

  task automatic check_writes(input string name, input int exp_n);
    checks++;
    if (wlog.size() != exp_n) begin
      errors++;
      $display("FAIL %s: write count got %0d expected %0d", name, wlog.size(), exp_n);
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    rx_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({ram_w_en, ram_addr, ram_w_data} !== 29'd0) begin
      errors++;
      $display("FAIL reset_ram: got en=%b addr=%h data=%h expected 0/000/0000",
               ram_w_en, ram_addr, ram_w_data);
    end
    check_status("reset_status", 1'b0, 1'b1, 2'd0);
    reset = 1'b1;
    wlog.delete();
  endtask

  task automatic test_good_load();
    apply_reset();
    drive(8'hA5); drive(8'h00); drive(8'h02); drive(8'h12); drive(8'h34);
    checks++;
    if ({ram_w_en, ram_addr, ram_w_data} !== {1'b1, 12'h000, 16'h1234}) begin
      errors++;
      $display("FAIL write_latency: got en=%b addr=%h data=%h expected 1/000/1234",
               ram_w_en, ram_addr, ram_w_data);
    end
    drive(8'hAB);
    checks++;
    if ({ram_w_en, ram_addr, ram_w_data} !== {1'b0, 12'h000, 16'h1234}) begin
      errors++;
      $display("FAIL write_hold: got en=%b addr=%h data=%h expected 0/000/1234",
               ram_w_en, ram_addr, ram_w_data);
    end
    drive(8'hCD); drive(8'h40);
    idle(2);
    check_writes("good_count", 2);
    checks++;
    if (wlog.size() == 2 && (wlog[0] !== {12'h000, 16'h1234} || wlog[1] !== {12'h001, 16'hABCD})) begin
      errors++;
      $display("FAIL good_data: got %h %h expected 0001234 001abcd", wlog[0], wlog[1]);
    end
    check_status("good_status", 1'b1, 1'b0, 2'd0);
    idle(70);
    check_status("done_no_timeout", 1'b1, 1'b0, 2'd0);
  endtask

  task automatic test_bad_checksum();
    apply_reset();
    drive(8'hA5); drive(8'h00); drive(8'h02); drive(8'h12); drive(8'h34);
    drive(8'hAB); drive(8'hCD); drive(8'h41);
    idle(2);
    check_writes("badcs_count", 2);
    check_status("badcs_status", 1'b0, 1'b1, 2'd1);
    drive(8'hA5); drive(8'h00); drive(8'h01); drive(8'h11); drive(8'h22); drive(8'h33);
    idle(2);
    check_writes("badcs_sticky_writes", 2);
    check_status("badcs_sticky", 1'b0, 1'b1, 2'd1);
  endtask

  task automatic test_empty_image();
    apply_reset();
    drive(8'h00); idle(1); drive(8'hFF); idle(1);
    drive(8'hA5); drive(8'h00); drive(8'h00); drive(8'h00);
    idle(2);
    check_writes("empty_count", 0);
    check_status("empty_status", 1'b1, 1'b0, 2'd0);
  endtask

  task automatic test_length_limit();
    apply_reset();
    drive(8'hA5); drive(8'h10); drive(8'h01);
    check_status("len_4097", 1'b0, 1'b1, 2'd2);
    idle(2);
    check_writes("len_4097_writes", 0);
    apply_reset();
    drive(8'hA5); drive(8'h10); drive(8'h00);
    check_status("len_4096_accept", 1'b0, 1'b1, 2'd0);
  endtask

  task automatic test_full_image();
    logic [7:0]  cs;
    logic [15:0] w;
    int bad;
    apply_reset();
    cs = 8'h00;
    drive(8'hA5); drive(8'h10); drive(8'h00);
    for (int i = 0; i < 4096; i++) begin
      w = 16'(i * 3 + 1);
      cs = cs ^ w[15:8] ^ w[7:0];
      drive(w[15:8]); drive(w[7:0]);
    end
    drive(cs);
    idle(2);
    check_writes("full_count", 4096);
    bad = 0;
    for (int i = 0; i < wlog.size() && i < 4096; i++) begin
      w = 16'(i * 3 + 1);
      if (wlog[i] !== {12'(i), w}) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL full_data: got %0d bad words expected 0 (last %h)", bad, wlog[wlog.size()-1]);
    end
    check_status("full_status", 1'b1, 1'b0, 2'd0);
  endtask

  task automatic test_timeout();
    apply_reset();
    drive(8'hA5); drive(8'h00); drive(8'h01); drive(8'h12);
    idle(49);
    check_status("timeout_before", 1'b0, 1'b1, 2'd0);
    idle(1);
    check_status("timeout_hit", 1'b0, 1'b1, 2'd3);
    apply_reset();
    drive(8'hA5); drive(8'h00); drive(8'h01); drive(8'h12);
    idle(49);
    drive(8'h34);
    checks++;
    if ({ram_w_en, ram_addr, ram_w_data} !== {1'b1, 12'h000, 16'h1234}) begin
      errors++;
      $display("FAIL timeout_edge_write: got en=%b addr=%h data=%h expected 1/000/1234",
               ram_w_en, ram_addr, ram_w_data);
    end
    check_status("timeout_edge_byte", 1'b0, 1'b1, 2'd0);
    idle(49);
    drive(8'h26);
    idle(1);
    check_status("timeout_edge_done", 1'b1, 1'b0, 2'd0);
  endtask

  task automatic test_reset_midload();
    apply_reset();
    drive(8'hA5); drive(8'h00); drive(8'h03); drive(8'h11); drive(8'h22);
    idle(1);
    check_writes("mid_first_word", 1);
    drive(8'h33);
    rx_valid = 1'b0;
    reset = 1'b0;
    #2;
    checks++;
    if ({ram_w_en, ram_addr, ram_w_data, load_done, cpu_hold, load_err} !== {1'b0, 12'h0, 16'h0, 1'b0, 1'b1, 2'd0}) begin
      errors++;
      $display("FAIL mid_reset_values: got en=%b addr=%h data=%h done=%b hold=%b err=%0d expected 0/000/0000/0/1/0",
               ram_w_en, ram_addr, ram_w_data, load_done, cpu_hold, load_err);
    end
    @(posedge clk); #1;
    reset = 1'b1;
    wlog.delete();
    drive(8'hA5); drive(8'h00); drive(8'h01); drive(8'hBE); drive(8'hEF); drive(8'h51);
    idle(2);
    check_writes("mid_new_count", 1);
    checks++;
    if (wlog.size() == 1 && wlog[0] !== {12'h000, 16'hBEEF}) begin
      errors++;
      $display("FAIL mid_new_data: got %h expected 000beef", wlog[0]);
    end
    check_status("mid_new_status", 1'b1, 1'b0, 2'd0);
  endtask

  initial begin
    #1;
    test_reset();
    test_good_load();
    test_bad_checksum();
    test_empty_image();
    test_length_limit();
    test_full_image();
    test_timeout();
    test_reset_midload();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
